// File: rtl/regop_pkg.sv
// Shared types and helpers for the round-robin arbiter that fronts the registered AND/NOT unit.
package regop_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    localparam int N_DEFAULT = 4;

    // A single requester still needs a 1-bit id, so never return zero.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regop_rr_arbiter_rr_pick.sv
// Round-robin winner selection: the first set request strictly after ptr, wrapping at N-1.
module rr_pick
    import regop_pkg::*;
#(
    parameter int N = N_DEFAULT,
    localparam int IDW = id_width(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           any,
    output logic [IDW-1:0] winner,
    output logic [N-1:0]   onehot
);

    always_comb begin
        any    = 1'b0;
        winner = '0;
        onehot = '0;
        // The offset reaches N so the previous winner is considered last.
        for (int off = 1; off <= N; off++) begin
            automatic int idx = (int'(ptr) + off) % N;
            if (!any && req[idx]) begin
                any         = 1'b1;
                winner      = IDW'(idx);
                onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regop_rr_arbiter.sv
// Arbitrates N requesters onto one registered y = a & b, w = ~c stage with a two-state FSM.
module regop_rr_arbiter
    import regop_pkg::*;
#(
    parameter int N = N_DEFAULT,
    localparam int IDW = id_width(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic [N-1:0]   c,
    output logic [N-1:0]   gnt,
    output logic           y,
    output logic           w,
    output logic           vld,
    output logic [IDW-1:0] id,
    output logic           busy
);

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win_id;
    logic           op_a;
    logic           op_b;
    logic           op_c;

    logic           pick_any;
    logic [IDW-1:0] pick_winner;
    logic [N-1:0]   pick_onehot;

    rr_pick #(.N(N)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .any    (pick_any),
        .winner (pick_winner),
        .onehot (pick_onehot)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            // Parking the pointer on the last index gives requester 0 first priority.
            ptr    <= IDW'(N - 1);
            win_id <= '0;
            op_a   <= 1'b0;
            op_b   <= 1'b0;
            op_c   <= 1'b0;
            gnt    <= '0;
            y      <= 1'b0;
            w      <= 1'b0;
            vld    <= 1'b0;
            id     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    vld <= 1'b0;
                    gnt <= '0;
                    if (pick_any) begin
                        gnt    <= pick_onehot;
                        op_a   <= a[pick_winner];
                        op_b   <= b[pick_winner];
                        op_c   <= c[pick_winner];
                        win_id <= pick_winner;
                        ptr    <= pick_winner;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    gnt   <= '0;
                    y     <= op_a & op_b;
                    w     <= ~op_c;
                    id    <= win_id;
                    vld   <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == EXEC);

endmodule

// File: tb/tb_regop_rr_arbiter.sv
// Directed bench for regop_rr_arbiter: reset, single grant, round-robin order, wrap, operand latch, mid-op reset.
module tb_regop_rr_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [N-1:0]   c;
    logic [N-1:0]   gnt;
    logic           y;
    logic           w;
    logic           vld;
    logic [IDW-1:0] id;
    logic           busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    regop_rr_arbiter #(.N(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .a    (a),
        .b    (b),
        .c    (c),
        .gnt  (gnt),
        .y    (y),
        .w    (w),
        .vld  (vld),
        .id   (id),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_idle_out(input string tag);
        chk({tag, ".gnt"},  32'(gnt),  32'h0);
        chk({tag, ".vld"},  32'(vld),  32'h0);
        chk({tag, ".y"},    32'(y),    32'h0);
        chk({tag, ".w"},    32'(w),    32'h0);
        chk({tag, ".id"},   32'(id),   32'h0);
        chk({tag, ".busy"}, 32'(busy), 32'h0);
    endtask

    task automatic chk_result(input string tag, input logic ey, input logic ew, input int eid);
        chk({tag, ".vld"},  32'(vld),  32'h1);
        chk({tag, ".gnt"},  32'(gnt),  32'h0);
        chk({tag, ".busy"}, 32'(busy), 32'h0);
        chk({tag, ".y"},    32'(y),    32'(ey));
        chk({tag, ".w"},    32'(w),    32'(ew));
        chk({tag, ".id"},   32'(id),   32'(eid));
        $display("txn %s: id=%0d y=%0b w=%0b", tag, id, y, w);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] exp_y;
        logic [4:0] exp_w;

        // 1. Reset held two cycles with every requester asserting.
        rst = 1'b0; req = 4'b1111; a = '0; b = '0; c = '0;
        tick();
        chk_idle_out("rst_c0");
        tick();
        chk_idle_out("rst_c1");
        rst = 1'b1;
        tick();
        chk("rst_first_gnt", 32'(gnt), 32'h1);
        chk("rst_first_busy", 32'(busy), 32'h1);
        chk("rst_first_novld", 32'(vld), 32'h0);
        req = 4'b0000;
        tick();
        chk_result("rst_first_res", 1'b0, 1'b1, 0);

        // 2. Lone request from requester 2.
        req = 4'b0100; a = 4'b0100; b = 4'b0100; c = 4'b0000;
        tick();
        chk("single_gnt", 32'(gnt), 32'h4);
        chk("single_novld", 32'(vld), 32'h0);
        req = 4'b0000;
        tick();
        chk_result("single_res", 1'b1, 1'b1, 2);
        tick();
        chk("single_vld_drop", 32'(vld), 32'h0);
        chk("single_y_hold", 32'(y), 32'h1);
        chk("single_w_hold", 32'(w), 32'h1);
        chk("single_id_hold", 32'(id), 32'h2);

        // 3. All requesting continuously from a fresh pointer; a=1, b=i[0], c=i[1].
        rst = 1'b0;
        tick();
        rst = 1'b1;
        req = 4'b1111; a = 4'b1111; b = 4'b1010; c = 4'b1100;
        exp_y = 5'b01010;
        exp_w = 5'b10011;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("rr%0d_gnt", i), 32'(gnt), 32'(1 << (i % 4)));
            chk($sformatf("rr%0d_novld", i), 32'(vld), 32'h0);
            tick();
            chk_result($sformatf("rr%0d_res", i), exp_y[i], exp_w[i], i % 4);
        end
        req = 4'b0000;

        // 4. Pointer wrap: 3, then {0,3} pending gives 0 then 3.
        a = 4'b0000; b = 4'b0000; c = 4'b0000;
        req = 4'b1000;
        tick();
        chk("wrap_gnt3", 32'(gnt), 32'h8);
        req = 4'b1001;
        tick();
        chk_result("wrap_res3", 1'b0, 1'b1, 3);
        tick();
        chk("wrap_gnt0", 32'(gnt), 32'h1);
        req = 4'b1000;
        tick();
        chk_result("wrap_res0", 1'b0, 1'b1, 0);
        tick();
        chk("wrap_gnt3_again", 32'(gnt), 32'h8);
        req = 4'b0000;
        tick();
        chk_result("wrap_res3_again", 1'b0, 1'b1, 3);

        // 5. Operands change right after the grant; the result uses the granted values.
        req = 4'b0010; a = 4'b0010; b = 4'b0010; c = 4'b0010;
        tick();
        chk("latch_gnt", 32'(gnt), 32'h2);
        req = 4'b0000; a = 4'b0000; b = 4'b0000; c = 4'b0000;
        tick();
        chk_result("latch_res", 1'b1, 1'b0, 1);

        // 6. Reset lands on the EXEC edge: transaction dropped, priority back to 0.
        req = 4'b0100; a = 4'b0100; b = 4'b0100; c = 4'b0000;
        tick();
        chk("midrst_gnt", 32'(gnt), 32'h4);
        chk("midrst_busy", 32'(busy), 32'h1);
        rst = 1'b0; req = 4'b1111;
        tick();
        chk_idle_out("midrst_drop");
        rst = 1'b1;
        tick();
        chk("midrst_next_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        tick();
        chk_result("midrst_next_res", 1'b0, 1'b1, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
